// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl
//   Sequences fade-in/fade-out of the 16-entry sprite colour palette. Base colours
//   are read from a combinational palette ROM, scaled by the current brightness
//   level and written into the working palette RAM in 16-cycle bursts. Bursts only
//   start on the vertical-blank frame pulse, so the renderer never sees a palette
//   that is half old and half new within one frame.
// Ports
//   Clk, Reset          clock and synchronous active-high reset
//   frame_pulse         1-cycle pulse at start of vertical blank
//   cmd_valid/ready     fade command handshake (ready only in IDLE)
//   cmd_dir             0 = fade out toward 0, 1 = fade in toward full brightness
//   cmd_frames          frames per level step (0 behaves as 1)
//   base_index/base_rgb palette ROM address and same-cycle {r,g,b} data
//   wr_en/addr/data     working palette RAM write port
//   level               current brightness level
//   busy, done          activity flag and 1-cycle command completion pulse
module palette_fade_ctrl (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_pulse,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_dir,
   input  logic [3:0]  cmd_frames,
   output logic [3:0]  base_index,
   input  logic [11:0] base_rgb,
   output logic        wr_en,
   output logic [3:0]  wr_addr,
   output logic [11:0] wr_data,
   output logic [3:0]  level,
   output logic        busy,
   output logic        done
);

   localparam int unsigned ENTRIES = 16;
   localparam int unsigned LVL_MAX = 15;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned LVL_W   = 4;
   localparam int unsigned FRM_W   = 4;
   localparam int unsigned CH_W    = 4;
   localparam int unsigned PROD_W  = 8;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);
   localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(LVL_MAX);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_BURST  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               dir_q, dir_d;
   logic [FRM_W-1:0]   frames_q, frames_d;
   logic [FRM_W-1:0]   fcnt_q, fcnt_d;
   logic               cmd_act_q, cmd_act_d;
   logic               refresh_pend_q, refresh_pend_d;

   // One colour channel scaled by (lvl+1)/16; max product 15*16 fits in 8 bits.
   function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                input logic [LVL_W-1:0] lvl);
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(c) * (PROD_W'(lvl) + PROD_W'(1));
      return CH_W'(prod >> CH_W);
   endfunction

   // True when the level has reached the end point of the given direction.
   function automatic logic at_target(input logic dir, input logic [LVL_W-1:0] lvl);
      return dir ? (lvl == LVL_TOP) : (lvl == '0);
   endfunction

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         level_q        <= LVL_TOP;
         dir_q          <= 1'b0;
         frames_q       <= FRM_W'(1);
         fcnt_q         <= '0;
         cmd_act_q      <= 1'b0;
         refresh_pend_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         level_q        <= level_d;
         dir_q          <= dir_d;
         frames_q       <= frames_d;
         fcnt_q         <= fcnt_d;
         cmd_act_q      <= cmd_act_d;
         refresh_pend_q <= refresh_pend_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      level_d        = level_q;
      dir_d          = dir_q;
      frames_d       = frames_q;
      fcnt_d         = fcnt_q;
      cmd_act_d      = cmd_act_q;
      refresh_pend_d = refresh_pend_q;

      case (state_q)
         S_IDLE: begin
            // An accepted command takes priority; a pending refresh waits for a later pulse.
            if (cmd_valid) begin
               dir_d     = cmd_dir;
               frames_d  = (cmd_frames == '0) ? FRM_W'(1) : cmd_frames;
               fcnt_d    = '0;
               cmd_act_d = 1'b1;
               state_d   = at_target(cmd_dir, level_q) ? S_FINISH : S_WAIT;
            end else if (frame_pulse && refresh_pend_q) begin
               refresh_pend_d = 1'b0;
               cmd_act_d      = 1'b0;
               idx_d          = '0;
               state_d        = S_BURST;
            end
         end
         S_WAIT: begin
            if (frame_pulse) begin
               if (fcnt_q + FRM_W'(1) == frames_q) begin
                  fcnt_d  = '0;
                  level_d = dir_q ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
                  idx_d   = '0;
                  state_d = S_BURST;
               end else begin
                  fcnt_d = fcnt_q + FRM_W'(1);
               end
            end
         end
         S_BURST: begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               idx_d = '0;
               if (!cmd_act_q)
                  state_d = S_IDLE;
               else if (at_target(dir_q, level_q))
                  state_d = S_FINISH;
               else
                  state_d = S_WAIT;
            end
         end
         S_FINISH: begin
            cmd_act_d = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state; write data follows the ROM combinationally.
   always_comb begin
      cmd_ready  = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_FINISH);
      wr_en      = (state_q == S_BURST);
      wr_addr    = idx_q;
      base_index = idx_q;
      level      = level_q;
      wr_data    = '0;
      if (state_q == S_BURST)
         wr_data = {scale_ch(base_rgb[11:8], level_q),
                    scale_ch(base_rgb[7:4],  level_q),
                    scale_ch(base_rgb[3:0],  level_q)};
   end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// tb_palette_fade_ctrl
//   Randomised bench for palette_fade_ctrl. A transaction-level model predicts the
//   writes and done pulses caused by each command and frame pulse and queues them;
//   a monitor on the falling edge pops and compares whatever the DUT presents.
module tb_palette_fade_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_pulse = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [3:0]  cmd_frames = 4'd0;
   logic [3:0]  base_index;
   logic [11:0] base_rgb;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [11:0] wr_data;
   logic [3:0]  level;
   logic        busy;
   logic        done;

   logic [11:0] rom [16];
   assign base_rgb = rom[base_index];

   palette_fade_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_pulse(frame_pulse),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_frames (cmd_frames),
      .base_index (base_index),
      .base_rgb   (base_rgb),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .level      (level),
      .busy       (busy),
      .done       (done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit is_done;
      int addr;
      int data;
      int lvl;
      bit after_burst;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   last_wr_cyc = -100;

   // Reference model state
   int m_level;
   bit m_pend;
   bit m_act;
   bit m_dir;
   int m_frames;
   int m_cnt;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int scale(input int rgb, input int lvl);
      int r, g, b;
      r = ((rgb >> 8) & 15) * (lvl + 1) / 16;
      g = ((rgb >> 4) & 15) * (lvl + 1) / 16;
      b = (rgb & 15) * (lvl + 1) / 16;
      return (r << 8) | (g << 4) | b;
   endfunction

   function automatic bit at_tgt(input bit d, input int l);
      return d ? (l == 15) : (l == 0);
   endfunction

   function automatic void push_burst(input int lvl);
      for (int i = 0; i < 16; i++) begin
         exp_t e;
         e.is_done = 1'b0;
         e.addr = i;
         e.data = scale(int'(rom[i]), lvl);
         e.lvl = lvl;
         e.after_burst = 1'b0;
         sb.push_back(e);
      end
   endfunction

   function automatic void push_done(input bit ab);
      exp_t e;
      e.is_done = 1'b1;
      e.addr = 0;
      e.data = 0;
      e.lvl = m_level;
      e.after_burst = ab;
      sb.push_back(e);
   endfunction

   function automatic void model_reset();
      m_level = 15;
      m_pend = 1'b1;
      m_act = 1'b0;
      m_cnt = 0;
   endfunction

   // Returns 1 when the command completes at once because the level is already at target.
   function automatic bit model_cmd(input bit d, input int f);
      m_dir = d;
      m_frames = (f == 0) ? 1 : f;
      m_cnt = 0;
      if (at_tgt(d, m_level)) begin
         push_done(1'b0);
         return 1'b1;
      end
      m_act = 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_pulse();
      if (m_act) begin
         m_cnt++;
         if (m_cnt == m_frames) begin
            m_cnt = 0;
            m_level = m_dir ? m_level + 1 : m_level - 1;
            push_burst(m_level);
            if (at_tgt(m_dir, m_level)) begin
               push_done(1'b1);
               m_act = 1'b0;
            end
         end
      end else if (m_pend) begin
         m_pend = 1'b0;
         push_burst(m_level);
      end
   endfunction

   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor: compares every write and done pulse against the head of the queue.
   always @(negedge Clk) begin
      exp_t e;
      if (wr_en === 1'b1) begin
         if (sb.size() == 0 || sb[0].is_done)
            check("unexpected_write", int'({wr_addr, wr_data}), -1);
         else begin
            e = sb.pop_front();
            check("write", int'({wr_addr, wr_data}), (e.addr << 12) | e.data);
         end
         last_wr_cyc = cyc;
      end
      if (done === 1'b1) begin
         if (sb.size() == 0 || !sb[0].is_done)
            check("unexpected_done", int'(done), 0);
         else begin
            e = sb.pop_front();
            if (e.after_burst) check("done_latency", cyc - last_wr_cyc, 1);
            check("done_level", int'(level), e.lvl);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic pulse();
      frame_pulse = 1'b1;
      tick(1);
      frame_pulse = 1'b0;
      model_pulse();
      check("level_after_pulse", int'(level), m_level);
   endtask

   task automatic issue_cmd(input bit d, input int f, input bit with_pulse);
      bit imm;
      check("cmd_ready_idle", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_dir = d;
      cmd_frames = 4'(f);
      frame_pulse = with_pulse;
      tick(1);
      cmd_valid = 1'b0;
      frame_pulse = 1'b0;
      imm = model_cmd(d, f);
      if (imm) check("done_immediate", int'(done), 1);
      check("busy_after_accept", int'(busy), 1);
   endtask

   // Pulses until the model says the command is complete; bounded by the level range.
   task automatic run_fade();
      while (m_act) begin
         pulse();
         tick(23);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench timed out at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 12'($urandom);
      rom[0] = 12'hFFF;
      rom[1] = 12'h000;
      rom[3] = 12'hF93;
      model_reset();
      Reset = 1'b1;
      tick(3);
      Reset = 1'b0;

      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_done", int'(done), 0);
      check("rst_level", int'(level), 15);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_base_index", int'(base_index), 0);
      check("rst_wr_data", int'(wr_data), 0);
      tick(2);

      // Initial full refresh at full brightness
      pulse();
      tick(23);

      // Fade out, one frame per step
      issue_cmd(1'b0, 1, 1'b0);
      tick(2);
      run_fade();
      check("level_faded_out", int'(level), 0);

      // Fade out while already dark completes at once
      issue_cmd(1'b0, 5, 1'b0);
      tick(3);

      // Fade in, frames=0 behaves as 1
      issue_cmd(1'b1, 0, 1'b0);
      tick(2);
      run_fade();
      check("level_faded_in", int'(level), 15);

      // Fade out, 3 frames per step; stray pulse and command during a burst
      issue_cmd(1'b0, 3, 1'b0);
      tick(2);
      pulse(); tick(23);
      pulse(); tick(23);
      pulse();
      tick(4);
      frame_pulse = 1'b1;
      cmd_valid = 1'b1;
      cmd_dir = 1'b1;
      cmd_frames = 4'd0;
      check("cmd_ready_in_burst", int'(cmd_ready), 0);
      check("busy_in_burst", int'(busy), 1);
      tick(1);
      frame_pulse = 1'b0;
      cmd_valid = 1'b0;
      tick(20);
      pulse(); tick(23);
      pulse(); tick(23);
      pulse();

      // Reset during burst entry 6
      tick(6);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      check("wr_en_after_reset", int'(wr_en), 0);
      check("level_after_reset", int'(level), 15);
      check("writes_before_reset", 16 - sb.size(), 7);
      sb.delete();
      model_reset();
      tick(2);
      pulse();
      tick(23);

      // Command and frame pulse together: command wins, refresh stays pending
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
      model_reset();
      tick(2);
      issue_cmd(1'b0, int'($urandom_range(0, 2)), 1'b1);
      tick(2);
      run_fade();
      pulse();
      tick(23);

      // Random commands with occasional idle pulses
      for (int r = 0; r < 5; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            pulse();
            tick(23);
         end
         issue_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
         tick(2);
         run_fade();
         tick(2);
      end

      tick(5);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
